// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver: 8N1 LSB-first UART receiver. It samples each bit at mid-symbol
// and presents received bytes on a valid/ready output port.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   serial_in       - asynchronous UART line, idle high
//   data_out        - received byte; data_out_valid marks it as unconsumed
//   data_out_ready  - consumer takes data_out when high with data_out_valid
//   rx_busy         - high while a frame is being received or awaiting line high
//   framing_error   - one-cycle pulse when the stop bit is sampled low
//   overrun         - sticky; an unconsumed byte was overwritten
module uart_receiver #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       rx_busy,
  output logic       framing_error,
  output logic       overrun
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             rx_meta;
  logic             rx_sync;

  // Two-flop synchronizer; preset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      rx_busy        <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      // Consumer handshake; a byte loading in this same cycle overrides the clear below.
      if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (!rx_sync) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        // Re-check the start bit at mid-symbol to reject short glitches.
        START: begin
          if (clk_cnt == SAMPLE_LAST) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // Counter was re-zeroed at mid-start, so each full symbol lands mid-bit.
        DATA: begin
          if (clk_cnt == SYMBOL_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (clk_cnt == SYMBOL_LAST) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              data_out       <= shift_reg;
              data_out_valid <= 1'b1;
              // Overwriting is only an overrun if the old byte is not leaving this cycle.
              if (data_out_valid && !data_out_ready) begin
                overrun <= 1'b1;
              end
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // A held-low line (break) must not be mistaken for a new start bit.
        WAIT_HIGH: begin
          clk_cnt <= '0;
          if (rx_sync) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning serial bit rate.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port serial_in  input  1  asynchronous UART line, idle high, 8N1 LSB-first.
REQ-006 SHALL have port data_out  output  8  received byte.
REQ-007 SHALL have port data_out_valid  output  1  data_out holds an unconsumed byte.
REQ-008 SHALL have port data_out_ready  input  1  consumer accepts data_out when high together with data_out_valid.
REQ-009 SHALL have port rx_busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 SHALL have port framing_error  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky flag: a byte was overwritten before consumption.

Function
REQ-012 SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE and SAMPLE_TIME = SYMBOL_EDGE_TIME/2 (integer division), with a clock counter of width $clog2(SYMBOL_EDGE_TIME).
REQ-013 SHALL pass serial_in through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: rx_sync==0 -> START, clock counter cleared to 0; otherwise remain.
REQ-016 START: when counter==SAMPLE_TIME-1, rx_sync==1 -> IDLE (glitch rejected, no outputs change); rx_sync==0 -> DATA, counter cleared, bit index 0.
REQ-017 DATA: when counter==SYMBOL_EDGE_TIME-1, shift rx_sync into bit 7 of shift register (right shift, LSB first), increment bit index, clear counter; after the 8th sample -> STOP.
REQ-018 STOP: when counter==SYMBOL_EDGE_TIME-1, rx_sync==1 -> load data_out from shift register, set data_out_valid, -> IDLE; rx_sync==0 -> pulse framing_error for exactly one cycle, data_out/data_out_valid unchanged, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_sync==1, then -> IDLE; no new frame starts while line is low.
REQ-020 Counter SHALL free-run (increment by 1) in START/DATA/STOP and hold 0 in IDLE/WAIT_HIGH.
REQ-021 data_out_valid SHALL clear on the cycle after a data_out_valid && data_out_ready handshake; data_out SHALL remain stable while data_out_valid is high and no new byte loads.
REQ-022 New byte loading while data_out_valid==1 and data_out_ready==0 SHALL overwrite data_out, keep data_out_valid high, and set overrun.
REQ-023 New byte loading in the same cycle as a handshake SHALL load the new byte, keep data_out_valid high, and NOT set overrun.
REQ-024 Latency: data_out_valid SHALL rise one cycle after the stop-bit sample point, nominally 2 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME cycles after the serial_in falling edge.
REQ-025 overrun SHALL remain high until reset.

Reset
REQ-026 On reset, SHALL force: FSM IDLE, counter 0, bit index 0, synchronizer flops 1, shift register 0, data_out 0x00, data_out_valid 0, framing_error 0, overrun 0; rx_busy therefore 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no partial byte delivered; reset SHALL take priority over every other event.

Verification (CLOCK_FREQ=125_000_000, BAUD_RATE=115_200: 1085 cycles/bit, SAMPLE_TIME 542)
REQ-028 Well-formed frame 0xA5, ready=1 -> data_out=0xA5, data_out_valid high exactly 1 cycle, framing_error 0, overrun 0.
REQ-029 Low glitch of 100 cycles on idle line -> rx_busy high then back to 0 at the start-sample point, data_out_valid stays 0.
REQ-030 Frame 0x3C with stop bit 0, line held low 3000 further cycles -> single framing_error pulse, data_out_valid 0, rx_busy held high until line returns high, next frame 0x81 received correctly.
REQ-031 Back-to-back frames 0x11 then 0x22, ready=0 -> data_out=0x22, data_out_valid=1, overrun=1; after one ready cycle, data_out_valid=0 and overrun still 1.
REQ-032 Reset pulse during data bit 4 of a frame -> all outputs at reset values next cycle; subsequent frame 0x5A -> data_out=0x5A with no framing_error.
REQ-033 Ready asserted in the exact cycle the second byte 0x7E loads -> data_out=0x7E, data_out_valid=1, overrun=0.
